// File: rtl/text_console_writer.sv
// Text-mode console writer: turns an ASCII byte stream into character RAM writes,
// tracking the cursor and scrolling by a circular row offset. Optional tab stops: CONSOLE_TAB_EN.
module text_console_writer #(
    parameter int unsigned COLS  = 70,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    input  logic [7:0]  in_ascii,
    output logic        in_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic [4:0]  scroll_base,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StClearLine, StClearAll} state_e;

    localparam logic [6:0]  LastCol  = 7'(COLS - 1);
    localparam logic [4:0]  RowMax   = 5'(ROWS - 1);
    localparam logic [11:0] ColsCnt  = 12'(COLS);
    localparam logic [11:0] TotalCnt = 12'(COLS * ROWS);

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] line_base_q, line_base_d;
    logic [4:0]  cur_row_q, cur_row_d;
    logic [6:0]  cur_col_q, cur_col_d;
    logic [4:0]  scroll_base_q, scroll_base_d;
    logic        wr_en_q, wr_en_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;

    logic [5:0]  row_sum;
    logic [4:0]  phys_row;
    logic [11:0] phys_addr;
    logic [11:0] base_addr;
    logic [4:0]  base_inc;
    logic        newline;
`ifdef CONSOLE_TAB_EN
    logic [7:0]  tab_col;
`endif

    // Circular row mapping without a divider: the sum never exceeds 2*ROWS-2.
    always_comb begin
        row_sum   = {1'b0, scroll_base_q} + {1'b0, cur_row_q};
        phys_row  = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
        phys_addr = 12'(phys_row) * ColsCnt + {5'b0, cur_col_q};
        base_addr = 12'(scroll_base_q) * ColsCnt;
        base_inc  = (scroll_base_q == RowMax) ? 5'd0 : scroll_base_q + 5'd1;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_base_d   = line_base_q;
        cur_row_d     = cur_row_q;
        cur_col_d     = cur_col_q;
        scroll_base_d = scroll_base_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        newline       = 1'b0;
`ifdef CONSOLE_TAB_EN
        tab_col       = {1'b0, cur_col_q | 7'd7} + 8'd1;
`endif

        case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    if (in_ascii >= 8'h20 && in_ascii <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = phys_addr;
                        wr_data_d = in_ascii;
                        if (cur_col_q == LastCol) begin
                            cur_col_d = 7'd0;
                            if (cur_row_q != RowMax) begin
                                cur_row_d = cur_row_q + 5'd1;
                            end else begin
                                // Character write owns this cycle; the scroll starts next cycle.
                                state_d     = StClearLine;
                                cnt_d       = 12'd0;
                                line_base_d = base_addr;
                            end
                        end else begin
                            cur_col_d = cur_col_q + 7'd1;
                        end
                    end else begin
                        case (in_ascii)
                            8'h0A: newline = 1'b1;
                            8'h0D: cur_col_d = 7'd0;
                            8'h08: begin
                                if (cur_col_q != 7'd0) begin
                                    cur_col_d = cur_col_q - 7'd1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = phys_addr - 12'd1;
                                    wr_data_d = BLANK;
                                end
                            end
                            8'h0C: begin
                                state_d   = StClearAll;
                                cnt_d     = 12'd1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = 12'd0;
                                wr_data_d = BLANK;
                            end
`ifdef CONSOLE_TAB_EN
                            8'h09: begin
                                if (tab_col >= 8'(COLS)) begin
                                    newline = 1'b1;
                                end else begin
                                    cur_col_d = tab_col[6:0];
                                end
                            end
`endif
                            default: ;
                        endcase
                    end

                    if (newline) begin
                        cur_col_d = 7'd0;
                        if (cur_row_q != RowMax) begin
                            cur_row_d = cur_row_q + 5'd1;
                        end else begin
                            // First blank of the recycled row goes out with the new base.
                            scroll_base_d = base_inc;
                            state_d       = StClearLine;
                            line_base_d   = base_addr;
                            cnt_d         = 12'd1;
                            wr_en_d       = 1'b1;
                            wr_addr_d     = base_addr;
                            wr_data_d     = BLANK;
                        end
                    end
                end
            end

            StClearLine: begin
                if (cnt_q == ColsCnt) begin
                    state_d = StIdle;
                end else begin
                    if (cnt_q == 12'd0) begin
                        scroll_base_d = base_inc;
                    end
                    wr_en_d   = 1'b1;
                    wr_addr_d = line_base_q + cnt_q;
                    wr_data_d = BLANK;
                    cnt_d     = cnt_q + 12'd1;
                end
            end

            StClearAll: begin
                if (cnt_q == TotalCnt) begin
                    state_d       = StIdle;
                    cur_row_d     = 5'd0;
                    cur_col_d     = 7'd0;
                    scroll_base_d = 5'd0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = BLANK;
                    cnt_d     = cnt_q + 12'd1;
                end
            end

            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle);
        busy_d     = ~in_ready_d;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= StClearAll;
            cnt_q         <= 12'd0;
            line_base_q   <= 12'd0;
            cur_row_q     <= 5'd0;
            cur_col_q     <= 7'd0;
            scroll_base_q <= 5'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 12'd0;
            wr_data_q     <= 8'd0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_base_q   <= line_base_d;
            cur_row_q     <= cur_row_d;
            cur_col_q     <= cur_col_d;
            scroll_base_q <= scroll_base_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign cur_row     = cur_row_q;
    assign cur_col     = cur_col_q;
    assign scroll_base = scroll_base_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed steps plus random bytes checked against a
// logical-screen model (2D array that shifts up on scroll) and a mirror of the character RAM.
module tb_text_console_writer;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ascii = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;
    logic [4:0]  scroll_base;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int oor   = 0;

    logic [7:0] ram [0:COLS*ROWS-1];
    logic [7:0] scr [0:ROWS-1][0:COLS-1];
    int mrow, mcol, mbase;

    text_console_writer dut (
        .clk         (clk),
        .clrn        (clrn),
        .in_valid    (in_valid),
        .in_ascii    (in_ascii),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cur_row     (cur_row),
        .cur_col     (cur_col),
        .scroll_base (scroll_base),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_addr < 12'(COLS * ROWS)) ram[wr_addr] <= wr_data;
            else oor <= oor + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cursor();
        return {20'd0, cur_row, cur_col};
    endfunction

    function automatic logic [31:0] mcursor(input int r, input int c);
        return 32'(r * 128 + c);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
        mrow = 0; mcol = 0; mbase = 0;
    endtask

    task automatic model_newline();
        mcol = 0;
        if (mrow < ROWS - 1) begin
            mrow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
            mbase = (mbase + 1) % ROWS;
        end
    endtask

    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow][mcol] = b;
            mcol++;
            if (mcol == COLS) model_newline();
        end else if (b == 8'h0A) model_newline();
        else if (b == 8'h0D) mcol = 0;
        else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                scr[mrow][mcol] = 8'h20;
            end
        end else if (b == 8'h0C) model_clear();
`ifdef CONSOLE_TAB_EN
        else if (b == 8'h09) begin
            int t;
            t = (mcol | 7) + 1;
            if (t >= COLS) model_newline();
            else mcol = t;
        end
`endif
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Returns at the sample point of the cycle right after acceptance.
    task automatic send(input logic [7:0] b);
        wait_ready();
        in_ascii = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        model_apply(b);
    endtask

    task automatic check_full_clear(input string tag);
        int errs = 0;
        for (int i = 0; i < COLS * ROWS; i++) begin
            @(negedge clk);
            if (!(wr_en === 1'b1 && wr_addr === 12'(i) && wr_data === 8'h20 && in_ready === 1'b0))
                errs++;
        end
        check(tag, 32'(errs), 32'd0);
        @(negedge clk);
        check({tag, "_ready"}, {30'd0, in_ready, busy}, 32'd2);
        check({tag, "_cursor"}, cursor(), 32'd0);
        check({tag, "_base"}, {27'd0, scroll_base}, 32'd0);
    endtask

    task automatic check_screen(input string tag);
        int errs = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (ram[((mbase + r) % ROWS) * COLS + c] !== scr[r][c]) errs++;
        check(tag, 32'(errs), 32'd0);
        check({tag, "_base"}, {27'd0, scroll_base}, 32'(mbase));
        check({tag, "_oor"}, 32'(oor), 32'd0);
    endtask

    initial begin
        int errs;
        logic [7:0] b;
        logic [7:0] others [0:5];
        others[0] = 8'h00; others[1] = 8'h07; others[2] = 8'h1B;
        others[3] = 8'h7F; others[4] = 8'h80; others[5] = 8'hFF;

        model_clear();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {in_ready, wr_en, wr_addr, wr_data, cur_row, cur_col, scroll_base, busy}, 32'd0);
        clrn = 1'b1;
        check_full_clear("init_clear");

        send(8'h41);
        check("a_write", {wr_en, 3'd0, wr_addr, wr_data}, {1'b1, 3'd0, 12'd0, 8'h41});
        check("a_cursor", cursor(), mcursor(0, 1));

        send(8'h0D);
        check("cr_nowrite", {31'd0, wr_en}, 32'd0);
        for (int i = 0; i < COLS; i++) send(8'h42);
        check("row_last_write", {wr_en, 3'd0, wr_addr, wr_data}, {1'b1, 3'd0, 12'd69, 8'h42});
        check("row_wrap_cursor", cursor(), mcursor(1, 0));

        for (int i = 0; i < 28; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h78);
        check("pre_scroll_cursor", cursor(), mcursor(29, 10));
        send(8'h0A);
        check("scroll_base_first", {27'd0, scroll_base}, 32'd1);
        errs = 0;
        for (int i = 0; i < COLS; i++) begin
            if (!(wr_en === 1'b1 && wr_addr === 12'(i) && wr_data === 8'h20 && in_ready === 1'b0))
                errs++;
            @(negedge clk);
        end
        check("scroll_clear", 32'(errs), 32'd0);
        check("scroll_ready", {30'd0, in_ready, wr_en}, 32'd2);
        check("scroll_cursor", cursor(), mcursor(29, 0));

        send(8'h0D);
        check("cr_last_row", {20'd0, wr_en, 4'd0, cur_row, cur_col},
              {20'd0, 1'b0, 4'd0, 5'd29, 7'd0});
        send(8'h43);
        check("wrapped_phys_row", {wr_en, 3'd0, wr_addr, wr_data}, {1'b1, 3'd0, 12'd0, 8'h43});

        send(8'h0C);
        wait_ready();
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61);
        send(8'h08);
        check("bs_write", {wr_en, 3'd0, wr_addr, wr_data}, {1'b1, 3'd0, 12'd144, 8'h20});
        check("bs_cursor", cursor(), mcursor(2, 4));
        send(8'h0D);
        send(8'h08);
        check("bs_col0", {20'd0, wr_en, 4'd0, cur_row, cur_col},
              {20'd0, 1'b0, 4'd0, 5'd2, 7'd0});

`ifdef CONSOLE_TAB_EN
        for (int i = 0; i < 3; i++) send(8'h62);
        send(8'h09);
        check("tab_col3", {20'd0, wr_en, 4'd0, cur_row, cur_col},
              {20'd0, 1'b0, 4'd0, 5'd2, 7'd8});
        send(8'h0D);
        for (int i = 0; i < 67; i++) send(8'h63);
        send(8'h09);
        check("tab_col67", cursor(), mcursor(3, 0));
`endif

        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 72)      b = 8'($urandom_range(32'h20, 32'h7E));
            else if (sel < 82) b = 8'h0A;
            else if (sel < 86) b = 8'h0D;
            else if (sel < 93) b = 8'h08;
            else if (sel < 96) b = 8'h09;
            else               b = others[$urandom_range(0, 5)];
            send(b);
            wait_ready();
            check("rand_cursor", cursor(), mcursor(mrow, mcol));
        end
        for (int i = 0; i < 3 * COLS; i++) send(8'h7A);
        wait_ready();
        @(negedge clk);
        check_screen("rand_screen");

        send(8'h0C);
        repeat (500) @(negedge clk);
        check("mid_clear_addr", {20'd0, wr_addr}, 32'd500);
        clrn = 1'b0;
        #1;
        check("mid_clear_reset",
              {in_ready, wr_en, wr_addr, wr_data, cur_row, cur_col, scroll_base, busy}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        model_clear();
        check_full_clear("reclear");
        check_screen("reclear_screen");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
